// File: rtl/ram_dp_be.sv
// Dual-port unified RAM: port A is a two-stage instruction fetch port, port B a
// byte-enabled load/store port with a single-entry valid/ready response stage.
module ram_dp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ia_req,
  input  logic [31:0]       ia_addr,
  output logic [DATA_W-1:0] ia_rdata,
  output logic              ia_valid,
  output logic              ia_err,
  input  logic              db_req,
  output logic              db_ready,
  input  logic              db_we,
  input  logic [1:0]        db_size,
  input  logic              db_unsigned,
  input  logic [31:0]       db_addr,
  input  logic [DATA_W-1:0] db_wdata,
  output logic [DATA_W-1:0] db_rdata,
  output logic              db_valid,
  output logic              db_err,
  input  logic              db_rsp_rdy
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int NB    = DATA_W / 8;
  localparam int TOP   = OFF_W + ADDR_W;

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Handshake: a port-B request is taken on any edge where db_req & db_ready;
  // the response is held in place until the edge where db_rsp_rdy = 1.
  logic [OFF_W-1:0]  w_ia_off;
  logic [ADDR_W-1:0] w_ia_idx;
  logic              w_ia_err;
  logic [OFF_W-1:0]  w_db_off;
  logic [ADDR_W-1:0] w_db_idx;
  logic [3:0]        w_db_nbytes;
  logic [3:0]        w_db_off4;
  logic              w_db_err;
  logic              w_accept;
  logic              w_do_store;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wsh;
  logic [DATA_W-1:0] w_rsh;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_load;
  logic              w_sign;

  logic              r_ia_p_valid;
  logic              r_ia_p_err;
  logic [DATA_W-1:0] r_ia_p_word;
  logic              r_ia_valid;
  logic              r_ia_err;
  logic [DATA_W-1:0] r_ia_rdata;
  logic              r_db_valid;
  logic              r_db_err;
  logic [DATA_W-1:0] r_db_rdata;

  assign w_ia_off = ia_addr[OFF_W-1:0];
  assign w_ia_idx = ia_addr[TOP-1:OFF_W];
  assign w_ia_err = (|(ia_addr >> TOP)) | (|w_ia_off);

  assign w_db_off    = db_addr[OFF_W-1:0];
  assign w_db_idx    = db_addr[TOP-1:OFF_W];
  assign w_db_nbytes = 4'd1 << db_size;
  assign w_db_off4   = 4'(w_db_off);
  assign w_db_err    = (|(db_addr >> TOP))
                     | (|(w_db_off4 & (w_db_nbytes - 4'd1)))
                     | ((db_size == 2'd3) && (DATA_W == 32));

  assign db_ready   = !r_db_valid | db_rsp_rdy;
  assign w_accept   = db_req & db_ready;
  assign w_do_store = w_accept & db_we & !w_db_err;

  always_comb begin
    w_be = '0;
    for (int i = 0; i < NB; i++) begin
      if ((i >= int'(w_db_off)) && (i < int'(w_db_off) + int'(w_db_nbytes)))
        w_be[i] = 1'b1;
    end
  end

  assign w_wsh = db_wdata << {w_db_off, 3'b000};
  assign w_rsh = r_mem[w_db_idx] >> {w_db_off, 3'b000};

  // Field mask and sign bit; a full-width field has an all-ones mask, so the
  // extension term vanishes and db_unsigned has no effect.
  always_comb begin
    int fbits;
    fbits = 8 << db_size;
    if (fbits > DATA_W) fbits = DATA_W;
    w_mask = '0;
    for (int i = 0; i < DATA_W; i++) w_mask[i] = (i < fbits);
    w_sign = w_rsh[fbits-1];
  end

  assign w_load = (w_rsh & w_mask) | ((w_sign & !db_unsigned) ? ~w_mask : '0);

  always_ff @(posedge clk) begin
    if (!rst && w_do_store) begin
      for (int i = 0; i < NB; i++) begin
        if (w_be[i]) r_mem[w_db_idx][i*8 +: 8] <= w_wsh[i*8 +: 8];
      end
    end
  end

  // Stage 1 samples the array with the old contents, giving read-before-write
  // against a same-edge port-B store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ia_p_valid <= 1'b0;
      r_ia_p_err   <= 1'b0;
      r_ia_p_word  <= '0;
      r_ia_valid   <= 1'b0;
      r_ia_err     <= 1'b0;
      r_ia_rdata   <= '0;
    end else begin
      r_ia_p_valid <= ia_req;
      r_ia_p_err   <= w_ia_err;
      r_ia_p_word  <= r_mem[w_ia_idx];
      r_ia_valid   <= r_ia_p_valid;
      r_ia_err     <= r_ia_p_valid & r_ia_p_err;
      r_ia_rdata   <= (r_ia_p_valid && !r_ia_p_err) ? r_ia_p_word : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_valid <= 1'b0;
      r_db_err   <= 1'b0;
      r_db_rdata <= '0;
    end else if (w_accept) begin
      r_db_valid <= 1'b1;
      r_db_err   <= w_db_err;
      r_db_rdata <= (db_we || w_db_err) ? '0 : w_load;
    end else if (db_rsp_rdy) begin
      r_db_valid <= 1'b0;
    end
  end

  assign ia_valid = r_ia_valid;
  assign ia_err   = r_ia_err;
  assign ia_rdata = r_ia_rdata;
  assign db_valid = r_db_valid;
  assign db_err   = r_db_err;
  assign db_rdata = r_db_rdata;

endmodule

// File: tb/tb_ram_dp_be.sv
// Randomized self-checking bench for ram_dp_be against a byte-array memory model.
module tb_ram_dp_be;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int BYTES  = (1 << ADDR_W) * (DATA_W / 8);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ia_req = 1'b0;
  logic [31:0]       ia_addr = '0;
  logic [DATA_W-1:0] ia_rdata;
  logic              ia_valid;
  logic              ia_err;
  logic              db_req = 1'b0;
  logic              db_ready;
  logic              db_we = 1'b0;
  logic [1:0]        db_size = '0;
  logic              db_unsigned = 1'b0;
  logic [31:0]       db_addr = '0;
  logic [DATA_W-1:0] db_wdata = '0;
  logic [DATA_W-1:0] db_rdata;
  logic              db_valid;
  logic              db_err;
  logic              db_rsp_rdy = 1'b1;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] m_mem [0:BYTES-1];

  ram_dp_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .ia_req(ia_req), .ia_addr(ia_addr), .ia_rdata(ia_rdata),
    .ia_valid(ia_valid), .ia_err(ia_err),
    .db_req(db_req), .db_ready(db_ready), .db_we(db_we), .db_size(db_size),
    .db_unsigned(db_unsigned), .db_addr(db_addr), .db_wdata(db_wdata),
    .db_rdata(db_rdata), .db_valid(db_valid), .db_err(db_err),
    .db_rsp_rdy(db_rsp_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic db_err_model(input logic [31:0] a, input logic [1:0] s);
    return (a >= BYTES) || ((a % (1 << s)) != 0) || (s == 2'd3);
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] a, input logic [1:0] s,
                                             input logic u);
    int n;
    logic [63:0] v;
    n = 1 << s;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(m_mem[a + i]) << (8 * i));
    if (!u && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic db_op(input logic we, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic chk_data);
    logic e;
    logic [31:0] exp_d;
    e = db_err_model(a, s);
    exp_d = (we || e) ? 32'd0 : load_model(a, s, u);
    @(negedge clk);
    db_req = 1'b1; db_we = we; db_size = s; db_unsigned = u;
    db_addr = a; db_wdata = wd; db_rsp_rdy = 1'b1;
    @(posedge clk); #1;
    db_req = 1'b0;
    if (we && !e) for (int i = 0; i < (1 << s); i++) m_mem[a + i] = wd[8*i +: 8];
    check("db_valid", 64'(db_valid), 64'd1);
    check("db_err", 64'(db_err), 64'(e));
    if (chk_data) check("db_rdata", 64'(db_rdata), 64'(exp_d));
  endtask

  function automatic logic [31:0] word_model(input logic [31:0] a);
    return {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
  endfunction

  task automatic fetch(input logic [31:0] a);
    logic e;
    logic [31:0] exp_d;
    e = (a >= BYTES) || (a[1:0] != 2'd0);
    exp_d = e ? 32'd0 : word_model(a);
    @(negedge clk);
    ia_req = 1'b1; ia_addr = a;
    @(negedge clk);
    ia_req = 1'b0;
    @(posedge clk); #1;
    check("ia_valid", 64'(ia_valid), 64'd1);
    check("ia_err", 64'(ia_err), 64'(e));
    check("ia_rdata", 64'(ia_rdata), 64'(exp_d));
  endtask

  initial begin
    logic [31:0] held;
    logic [1:0]  s;
    logic [31:0] a;

    // reset state
    #12;
    check("rst_ia_valid", 64'(ia_valid), 64'd0);
    check("rst_db_valid", 64'(db_valid), 64'd0);
    check("rst_db_ready", 64'(db_ready), 64'd1);
    @(negedge clk); rst = 1'b0;

    // unwritten word: only the error flag is defined
    db_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);

    // mid-stream reset with a held response and a fetch in flight
    @(negedge clk);
    ia_req = 1'b1; ia_addr = 32'h0;
    db_req = 1'b1; db_we = 1'b0; db_size = 2'd2; db_addr = 32'h44; db_rsp_rdy = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_db_valid", 64'(db_valid), 64'd1);
    @(negedge clk); ia_req = 1'b0; db_req = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_ia_valid", 64'(ia_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_db_valid", 64'(db_valid), 64'd0);
    check("arst_ia_valid", 64'(ia_valid), 64'd0);
    check("arst_db_rdata", 64'(db_rdata), 64'd0);
    check("arst_ia_rdata", 64'(ia_rdata), 64'd0);
    check("arst_db_ready", 64'(db_ready), 64'd1);
    @(negedge clk); rst = 1'b0; db_rsp_rdy = 1'b1;

    for (int w = 0; w < (1 << ADDR_W); w++) db_op(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b1);

    // byte-lane stores and extension
    db_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b1);
    db_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 1'b1);
    db_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, 1'b1);
    db_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    check("word_0x10", 64'(db_rdata), 64'hBEEFAA44);
    db_op(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1);
    check("sbyte_0x11", 64'(db_rdata), 64'hFFFFFFAA);
    db_op(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b1);
    check("ubyte_0x11", 64'(db_rdata), 64'h000000AA);
    db_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1);
    check("shalf_0x12", 64'(db_rdata), 64'hFFFFBEEF);

    // errors
    db_op(1'b1, 2'd1, 1'b0, 32'h13, 32'h00005555, 1'b1);
    check("misal_store_err", 64'(db_err), 64'd1);
    db_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1);
    check("unchanged_0x10", 64'(db_rdata), 64'hBEEFAA44);
    fetch(32'h02);
    check("fetch_misal_err", 64'(ia_err), 64'd1);
    db_op(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1);
    check("oor_load_err", 64'(db_err), 64'd1);
    db_op(1'b0, 2'd3, 1'b0, 32'h18, 32'h0, 1'b1);
    fetch(32'h10);

    // backpressure
    @(negedge clk);
    db_req = 1'b1; db_we = 1'b0; db_size = 2'd2; db_unsigned = 1'b0;
    db_addr = 32'h10; db_rsp_rdy = 1'b0;
    @(posedge clk); #1;
    held = db_rdata;
    check("bp_first", 64'(held), 64'hBEEFAA44);
    @(negedge clk); db_addr = 32'h14;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("bp_valid", 64'(db_valid), 64'd1);
      check("bp_hold", 64'(db_rdata), 64'(held));
      check("bp_ready", 64'(db_ready), 64'd0);
    end
    @(negedge clk); db_rsp_rdy = 1'b1; #1;
    check("bp_ready_rel", 64'(db_ready), 64'd1);
    @(posedge clk); #1;
    db_req = 1'b0;
    check("bp_second", 64'(db_rdata), 64'(word_model(32'h14)));
    check("bp_second_v", 64'(db_valid), 64'd1);
    @(posedge clk); #1;
    check("bp_drop", 64'(db_valid), 64'd0);

    // same-edge collision
    db_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
    @(negedge clk);
    ia_req = 1'b1; ia_addr = 32'h20;
    db_req = 1'b1; db_we = 1'b1; db_size = 2'd2; db_addr = 32'h20; db_wdata = 32'h12345678;
    @(negedge clk);
    db_req = 1'b0;
    for (int i = 0; i < 4; i++) m_mem[32 + i] = db_wdata[8*i +: 8];
    @(posedge clk); #1;
    check("coll_old", 64'(ia_rdata), 64'h0);
    @(negedge clk); ia_req = 1'b0;
    @(posedge clk); #1;
    check("coll_new", 64'(ia_rdata), 64'h12345678);
    @(posedge clk); #1;
    check("ia_pulse", 64'(ia_valid), 64'd0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 9) < 7) a = a & ~(32'(1 << s) - 32'd1);
      db_op(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        a = 32'($urandom_range(0, BYTES + 15));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'd0;
        fetch(a);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Parametrised dual-port unified memory, the next generation of the core's instruction/data RAM. Port A is a read-only instruction-fetch port. Port B is a load/store port with byte, halfword, word and (for wide configs) doubleword accesses, load sign/zero extension, alignment checking and a valid/ready response handshake. Both ports have registered responses. The block sits between the fetch stage and LSU on one side and a single synchronous memory array on the other, and replaces the bidirectional data bus with separate write and read buses.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be 32 or 64
- ADDR_W, 7, word-address width; depth = 2**ADDR_W words
- OFF_W, derived = log2(DATA_W/8), count of byte-offset bits

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- ia_req  in  1  fetch request
- ia_addr  in  32  fetch byte address
- ia_rdata  out  DATA_W  fetched word
- ia_valid  out  1  fetch response valid (one-cycle pulse)
- ia_err  out  1  fetch error, qualified by ia_valid
- db_req  in  1  data request
- db_ready  out  1  port B can accept a request this cycle
- db_we  in  1  1 = store, 0 = load
- db_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W = 64)
- db_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- db_addr  in  32  data byte address
- db_wdata  in  DATA_W  store data, right-aligned (field in the low bits)
- db_rdata  out  DATA_W  load result, right-aligned and extended
- db_valid  out  1  data response valid, held until accepted
- db_err  out  1  data error, qualified by db_valid
- db_rsp_rdy  in  1  consumer accepts the port-B response

## Operation
- Address decode: offset = addr[OFF_W-1:0]; word index = addr[OFF_W+ADDR_W-1:OFF_W]. Any set bit above OFF_W+ADDR_W-1 is out of range.
- Port A:
  - Accepts a request every cycle ia_req = 1.
  - Error if offset ≠ 0 or the address is out of range. On error ia_rdata = 0.
- Port B acceptance: a request is accepted when db_req & db_ready.
  - db_ready = !db_valid | db_rsp_rdy. This is a single-entry pipeline stage.
  - Back-to-back accepts at full throughput are allowed while db_rsp_rdy = 1.
- Port B error conditions: size not aligned (offset mod 2**size ≠ 0), size = 3 when DATA_W = 32, or address out of range.
  - An errored store does not modify memory.
  - An errored load returns db_rdata = 0.
- Store: writes (8 << size) bits taken from db_wdata[(8<<size)-1:0] into byte lanes offset .. offset+2**size-1. All other lanes are unchanged.
- Load: extracts the field at the offset, shifts it to bit 0, then extends it to DATA_W according to db_unsigned. Size equal to DATA_W ignores db_unsigned.
- A store response has db_valid = 1, db_err as computed, and db_rdata = 0.
- Memory contents are not reset; they are undefined until written.

## Timing
- Reset values: ia_valid, ia_err, ia_rdata, db_valid, db_err and db_rdata are all 0. db_ready is 1 while rst = 1 and after release.
- While rst = 1, no request is accepted and memory is not written.
- Reset asserted mid-operation drops any pending response. No partial store occurs.
- Port A latency: request at edge N gives ia_valid = 1 with data after edge N+1, for exactly one cycle per request.
- Port B latency: accepted at edge N gives db_valid = 1 after edge N. The store commits to the array at edge N.
- Port B response hold: if db_rsp_rdy = 0, db_valid, db_rdata and db_err hold unchanged and db_ready = 0.
- Port B response drop: db_valid falls after the accept edge unless a new request is accepted on that same edge.
- Same-edge collision: a port-A fetch and a port-B store to the same word on the same edge → port A returns the pre-store word (read-before-write).
- Port B store then load to the same word on consecutive accepts → the load sees the stored data.
- Simultaneous port A and port B loads of the same word are both served with no stall.

## Test plan
- Reset: assert rst mid-stream with db_valid = 1 → all outputs 0 asynchronously, db_ready = 1. After release, a load of a previously unwritten address has db_err = 0.
- Byte stores: store word 0x11223344 at byte address 0x10. Then byte store 0xAA at 0x11, half store 0xBEEF at 0x12. Word load at 0x10 → 0xBEEFAA44.
- Extension:
  - From the memory state above: signed byte load at 0x11 → 0xFFFFFFAA.
  - Unsigned byte load at 0x11 → 0x000000AA.
  - Signed half load at 0x12 → 0xFFFFBEEF.
- Errors:
  - Half store at 0x13 → db_err = 1 and memory unchanged.
  - Fetch at 0x02 → ia_err = 1, ia_rdata = 0.
  - Word load at 0x200 (ADDR_W = 7) → db_err = 1.
- Backpressure: hold db_rsp_rdy = 0 for 3 cycles after a load → db_valid and data stable, db_ready = 0, a second db_req is not accepted. Release → the second request is accepted on that edge.
- Collision: word 0x20 holds 0x0. On the same edge, fetch 0x20 and store 0x12345678 to 0x20 → ia_rdata = 0x0. A fetch on the next edge → 0x12345678.
